alu_op_sequencer: RTL and testbench

//  Initiator side of the ALU unit interface. Accepts one operation at a time on a valid/ready

---
 rtl/alu_pkg.sv | 12 +
 rtl/cmp_result_decoder.sv | 17 +
 rtl/alu_op_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared unit-select codes, compare result codes and sequencer state encoding
package alu_pkg;
    localparam logic [1:0] UNIT_ARITH = 2'd0;
    localparam logic [1:0] UNIT_LOGIC = 2'd1;
    localparam logic [1:0] UNIT_CMP   = 2'd2;
    localparam logic [1:0] UNIT_SHIFT = 2'd3;
    localparam logic [1:0] CMP_NONE   = 2'd0;
    localparam logic [1:0] CMP_EQ     = 2'd1;
    localparam logic [1:0] CMP_GT     = 2'd2;
    localparam logic [1:0] CMP_LT     = 2'd3;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/cmp_result_decoder.sv
// cmp_result_decoder: maps the compare unit's raw code onto eq/gt/lt and flags unknown codes
module cmp_result_decoder
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] cmp_out,
    output logic                  eq,
    output logic                  gt,
    output logic                  lt,
    output logic                  illegal
);
    assign eq      = cmp_out == DATA_WIDTH'(CMP_EQ);
    assign gt      = cmp_out == DATA_WIDTH'(CMP_GT);
    assign lt      = cmp_out == DATA_WIDTH'(CMP_LT);
    assign illegal = cmp_out >  DATA_WIDTH'(CMP_LT);
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one command at a time to an ALU unit and returns its captured result
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int UNIT_LAT   = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    input  logic [3:0]            cmd_fun,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [3:0]            ALU_FUN,
    output logic                  Arith_Enable,
    output logic                  Logic_Enable,
    output logic                  CMP_Enable,
    output logic                  SHIFT_Enable,
    input  logic [DATA_WIDTH-1:0] Arith_OUT,
    input  logic [DATA_WIDTH-1:0] Logic_OUT,
    input  logic [DATA_WIDTH-1:0] CMP_OUT,
    input  logic [DATA_WIDTH-1:0] SHIFT_OUT,
    input  logic                  Arith_Flag,
    input  logic                  Logic_Flag,
    input  logic                  CMP_Flag,
    input  logic                  SHIFT_Flag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_unit,
    output logic                  rsp_eq,
    output logic                  rsp_gt,
    output logic                  rsp_lt,
    output logic                  rsp_err,
    output logic [CNT_WIDTH-1:0]  op_count
);
    localparam int LW = (UNIT_LAT > 1) ? $clog2(UNIT_LAT) : 1;

    state_t                  state, state_nx;
    logic [LW-1:0]           cnt;
    logic [3:0]              en;
    logic [DATA_WIDTH-1:0]   sel_out;
    logic                    sel_flag, is_cmp, dec_eq, dec_gt, dec_lt, dec_illegal;

    assign Arith_Enable = en[0];
    assign Logic_Enable = en[1];
    assign CMP_Enable   = en[2];
    assign SHIFT_Enable = en[3];
    assign is_cmp       = ALU_FUN[3:2] == UNIT_CMP;

    cmp_result_decoder #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
        .cmp_out (CMP_OUT),
        .eq      (dec_eq),
        .gt      (dec_gt),
        .lt      (dec_lt),
        .illegal (dec_illegal)
    );

    // state register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;

    // next state: WAIT exits once the latency counter has run down to zero
    always_comb begin
        state_nx = (state == S_IDLE)  ? (cmd_valid ? S_ISSUE : S_IDLE) :
                   (state == S_ISSUE) ? S_WAIT :
                   (state == S_WAIT)  ? ((cnt == '0) ? S_RESP : S_WAIT) :
                                        (rsp_ready ? S_IDLE : S_RESP);
    end

    // handshake strobes decoded straight from the registered state
    always_comb begin
        cmd_ready = state == S_IDLE;
        rsp_valid = state == S_RESP;
    end

    // pick the result and flag of the unit named by the issued function
    always_comb begin
        sel_out  = (ALU_FUN[3:2] == UNIT_ARITH) ? Arith_OUT :
                   (ALU_FUN[3:2] == UNIT_LOGIC) ? Logic_OUT :
                   (ALU_FUN[3:2] == UNIT_CMP)   ? CMP_OUT   : SHIFT_OUT;
        sel_flag = (ALU_FUN[3:2] == UNIT_ARITH) ? Arith_Flag :
                   (ALU_FUN[3:2] == UNIT_LOGIC) ? Logic_Flag :
                   (ALU_FUN[3:2] == UNIT_CMP)   ? CMP_Flag   : SHIFT_Flag;
    end

    // operand issue, latency countdown, result capture (enable held through it) and op counting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            A        <= '0;
            B        <= '0;
            ALU_FUN  <= '0;
            en       <= '0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_unit <= '0;
            rsp_eq   <= 1'b0;
            rsp_gt   <= 1'b0;
            rsp_lt   <= 1'b0;
            rsp_err  <= 1'b0;
            op_count <= '0;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                A       <= cmd_a;
                B       <= cmd_b;
                ALU_FUN <= cmd_fun;
                en      <= 4'b0001 << cmd_fun[3:2];
            end
            if (state == S_ISSUE)
                cnt <= LW'(UNIT_LAT - 1);
            if (state == S_WAIT) begin
                if (cnt != '0) begin
                    cnt <= cnt - LW'(1);
                end else begin
                    en       <= '0;
                    rsp_data <= sel_out;
                    rsp_unit <= ALU_FUN[3:2];
                    rsp_eq   <= is_cmp & dec_eq;
                    rsp_gt   <= is_cmp & dec_gt;
                    rsp_lt   <= is_cmp & dec_lt;
                    rsp_err  <= ~sel_flag | (is_cmp & dec_illegal);
                end
            end
            if (state == S_RESP && rsp_ready)
                op_count <= op_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: vector table, random ops against a rule model, latency/wrap/reset sequences
module tb_alu_op_sequencer;
    localparam int DW = 16;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  unit;
        logic        eq, gt, lt, err;
    } exp_t;

    typedef struct {
        logic [3:0]  fun;
        logic [15:0] a, b, uo;
        logic        uf;
        int          hold;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    int cnt3 = 0;

    logic [DW-1:0] u_out [4];
    logic          u_flag [4];

    logic          cmd_valid = 1'b0, cmd_valid3 = 1'b0;
    logic [DW-1:0] cmd_a = '0, cmd_b = '0;
    logic [3:0]    cmd_fun = '0;
    logic          rsp_ready = 1'b0, rsp_ready3 = 1'b1;

    logic          cmd_ready, ae, le, ce, se, aflag, lflag, cflag, sflag;
    logic          rsp_valid, rsp_eq, rsp_gt, rsp_lt, rsp_err;
    logic [DW-1:0] A, B, aout, lout, cout, sout, rsp_data;
    logic [3:0]    ALU_FUN;
    logic [1:0]    rsp_unit;
    logic [15:0]   op_count;

    logic          cmd_ready3, ae3, le3, ce3, se3, aflag3, lflag3, cflag3, sflag3;
    logic          rsp_valid3, rsp_eq3, rsp_gt3, rsp_lt3, rsp_err3;
    logic [DW-1:0] A3, B3, aout3, lout3, cout3, sout3, rsp_data3;
    logic [3:0]    ALU_FUN3;
    logic [1:0]    rsp_unit3;
    logic [2:0]    op_count3;

    logic [3:0] en1, en3;
    exp_t got1, got3;
    assign en1  = {se, ce, le, ae};
    assign en3  = {se3, ce3, le3, ae3};
    assign got1 = {rsp_data, rsp_unit, rsp_eq, rsp_gt, rsp_lt, rsp_err};
    assign got3 = {rsp_data3, rsp_unit3, rsp_eq3, rsp_gt3, rsp_lt3, rsp_err3};

    // unit models: result and flag appear only after the enable has been high for UNIT_LAT edges
    int hi1, hi3;
    always @(posedge clk or negedge rst)
        if (!rst) begin hi1 <= 0; hi3 <= 0; end
        else begin
            hi1 <= (en1 != 0) ? hi1 + 1 : 0;
            hi3 <= (en3 != 0) ? hi3 + 1 : 0;
        end
    logic ok1, ok3;
    assign ok1 = hi1 >= 1;
    assign ok3 = hi3 >= 3;
    assign aout  = (ae && ok1) ? u_out[0] : '0;
    assign lout  = (le && ok1) ? u_out[1] : '0;
    assign cout  = (ce && ok1) ? u_out[2] : '0;
    assign sout  = (se && ok1) ? u_out[3] : '0;
    assign aflag = ae && ok1 && u_flag[0];
    assign lflag = le && ok1 && u_flag[1];
    assign cflag = ce && ok1 && u_flag[2];
    assign sflag = se && ok1 && u_flag[3];
    assign aout3  = (ae3 && ok3) ? u_out[0] : '0;
    assign lout3  = (le3 && ok3) ? u_out[1] : '0;
    assign cout3  = (ce3 && ok3) ? u_out[2] : '0;
    assign sout3  = (se3 && ok3) ? u_out[3] : '0;
    assign aflag3 = ae3 && ok3 && u_flag[0];
    assign lflag3 = le3 && ok3 && u_flag[1];
    assign cflag3 = ce3 && ok3 && u_flag[2];
    assign sflag3 = se3 && ok3 && u_flag[3];

    alu_op_sequencer #(.DATA_WIDTH(DW), .UNIT_LAT(1), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun), .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .Arith_Enable(ae), .Logic_Enable(le), .CMP_Enable(ce), .SHIFT_Enable(se),
        .Arith_OUT(aout), .Logic_OUT(lout), .CMP_OUT(cout), .SHIFT_OUT(sout),
        .Arith_Flag(aflag), .Logic_Flag(lflag), .CMP_Flag(cflag), .SHIFT_Flag(sflag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_unit(rsp_unit),
        .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .rsp_lt(rsp_lt), .rsp_err(rsp_err), .op_count(op_count)
    );

    alu_op_sequencer #(.DATA_WIDTH(DW), .UNIT_LAT(3), .CNT_WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun), .A(A3), .B(B3), .ALU_FUN(ALU_FUN3),
        .Arith_Enable(ae3), .Logic_Enable(le3), .CMP_Enable(ce3), .SHIFT_Enable(se3),
        .Arith_OUT(aout3), .Logic_OUT(lout3), .CMP_OUT(cout3), .SHIFT_OUT(sout3),
        .Arith_Flag(aflag3), .Logic_Flag(lflag3), .CMP_Flag(cflag3), .SHIFT_Flag(sflag3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_unit(rsp_unit3),
        .rsp_eq(rsp_eq3), .rsp_gt(rsp_gt3), .rsp_lt(rsp_lt3), .rsp_err(rsp_err3), .op_count(op_count3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // expected response from the interface rules: raw result, unit echo, compare decode, error
    function automatic exp_t model(input logic [3:0] fun, input logic [15:0] uo, input logic uf);
        exp_t r;
        r = '{data: uo, unit: fun[3:2], eq: 1'b0, gt: 1'b0, lt: 1'b0, err: !uf};
        if (fun[3:2] == 2'b10) begin
            if (uo == 16'd1)      r.eq = 1'b1;
            else if (uo == 16'd2) r.gt = 1'b1;
            else if (uo == 16'd3) r.lt = 1'b1;
            else if (uo != 16'd0) r.err = 1'b1;
        end
        return r;
    endfunction

    // one full operation on the UNIT_LAT=1 instance, holding the response for 'hold' cycles
    task automatic run_op(input string nm, input logic [3:0] fun, input logic [15:0] a, b, uo,
                          input logic uf, input int hold, input exp_t e);
        int k, acc;
        u_out[fun[3:2]]  = uo;
        u_flag[fun[3:2]] = uf;
        cmd_a = a; cmd_b = b; cmd_fun = fun; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 20) begin @(posedge clk); #1; k++; end
        chk({nm, " ready-wait"}, 64'(k), 64'(0));
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid = 1'b0;
        chk({nm, " issue"}, 64'({A, B, ALU_FUN, en1, cmd_ready}),
            64'({a, b, fun, 4'(4'b0001 << fun[3:2]), 1'b0}));
        k = 0;
        while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
        chk({nm, " latency"}, 64'(cyc - acc), 64'(2));
        chk({nm, " rsp"}, 64'({got1, en1}), 64'({e, 4'b0000}));
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_a = ~a; cmd_fun = ~fun;
            @(posedge clk); #1;
            chk({nm, " hold"}, 64'({rsp_valid, cmd_ready, en1, got1, op_count}),
                64'({1'b1, 1'b0, 4'b0000, e, 16'(exp_cnt)}));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_cnt++;
        chk({nm, " done"}, 64'({rsp_valid, cmd_ready, op_count, A, ALU_FUN}),
            64'({1'b0, 1'b1, 16'(exp_cnt), a, fun}));
    endtask

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{4'b1001, 16'h1234, 16'h1234, 16'h0001, 1'b1, 0,  '{16'h0001, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[1]  = '{4'b1011, 16'h0005, 16'h0009, 16'h0003, 1'b1, 0,  '{16'h0003, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[2]  = '{4'b1011, 16'h0005, 16'h0009, 16'h0007, 1'b1, 0,  '{16'h0007, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[3]  = '{4'b1000, 16'h0009, 16'h0005, 16'h0002, 1'b1, 0,  '{16'h0002, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[4]  = '{4'b1010, 16'h0007, 16'h0003, 16'h0000, 1'b1, 0,  '{16'h0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[5]  = '{4'b0000, 16'h0010, 16'h0020, 16'h0030, 1'b0, 0,  '{16'h0030, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[6]  = '{4'b0101, 16'hF0F0, 16'h5555, 16'hA5A5, 1'b1, 0,  '{16'hA5A5, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[7]  = '{4'b1110, 16'h4000, 16'h0001, 16'h8001, 1'b1, 10, '{16'h8001, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[8]  = '{4'b1001, 16'h0001, 16'h0001, 16'h0001, 1'b0, 0,  '{16'h0001, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[9]  = '{4'b1001, 16'h0002, 16'h0003, 16'hFFFF, 1'b1, 0,  '{16'hFFFF, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[10] = '{4'b0011, 16'h0000, 16'h0001, 16'h0001, 1'b1, 0,  '{16'h0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}};
        for (int i = 0; i < 4; i++) begin u_out[i] = '0; u_flag[i] = 1'b0; end

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("reset state", 64'({A, B, ALU_FUN, en1, rsp_valid, got1, op_count, cmd_ready}),
            64'({16'h0, 16'h0, 4'h0, 4'h0, 1'b0, 22'h0, 16'h0, 1'b1}));
        chk("reset state lat3", 64'({en3, rsp_valid3, got3, op_count3, cmd_ready3}),
            64'({4'h0, 1'b0, 22'h0, 3'h0, 1'b1}));

        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vecs[i].fun, vecs[i].a, vecs[i].b, vecs[i].uo,
                   vecs[i].uf, vecs[i].hold, vecs[i].e);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  f;
            logic [15:0] uo;
            logic        uf;
            f  = 4'($urandom);
            uo = (f[3:2] == 2'b10) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            uf = $urandom_range(0, 4) != 0;
            run_op($sformatf("rand%0d", i), f, 16'($urandom), 16'($urandom), uo, uf,
                   $urandom_range(0, 3), model(f, uo, uf));
        end

        for (int i = 0; i < 9; i++) begin
            int k, acc;
            u_out[1] = 16'(i * 3 + 1); u_flag[1] = 1'b1;
            cmd_fun = 4'b0110; cmd_a = 16'(i); cmd_valid3 = 1'b1;
            k = 0;
            while (!cmd_ready3 && k < 20) begin @(posedge clk); #1; k++; end
            @(posedge clk); #1;
            acc = cyc;
            cmd_valid3 = 1'b0;
            k = 0;
            while (!rsp_valid3 && k < 20) begin @(posedge clk); #1; k++; end
            chk($sformatf("lat3 latency%0d", i), 64'(cyc - acc), 64'(4));
            chk($sformatf("lat3 rsp%0d", i), 64'(got3), 64'({16'(i * 3 + 1), 2'd1, 4'b0000}));
            @(posedge clk); #1;
            cnt3++;
            chk($sformatf("lat3 count%0d", i), 64'({rsp_valid3, op_count3}), 64'({1'b0, 3'(cnt3)}));
        end

        cmd_fun = 4'b0001; cmd_a = 16'hDEAD; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset in flight", 64'({en1, cmd_ready}), 64'({4'b0001, 1'b0}));
        #2 rst = 1'b0;
        #1;
        chk("async reset", 64'({A, B, ALU_FUN, en1, rsp_valid, got1, op_count, op_count3, cmd_ready}),
            64'({16'h0, 16'h0, 4'h0, 4'h0, 1'b0, 22'h0, 16'h0, 3'h0, 1'b1}));
        exp_cnt = 0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("after reset", 64'({cmd_ready, en1, rsp_valid, op_count}), 64'({1'b1, 4'h0, 1'b0, 16'h0}));
        run_op("post-reset", 4'b1011, 16'h0005, 16'h0009, 16'h0003, 1'b1, 0, model(4'b1011, 16'h0003, 1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
